serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b - borrow_in one bit per clock, LSB first.
- Uses a single full-subtract bit cell plus a registered borrow, trading latency for area.
- Chains directly downstream of the single-bit full-subtractor datapath.
- Sits between an operand source (start/operand handshake) and a result consumer (done pulse, held result).

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- start  input  1  request; accepted only when state is IDLE or DONE.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- borrow_in  input  1  initial borrow; sampled only on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; diff/borrow_out valid from this cycle.
- diff  output  WIDTH  result (a - b - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Behaviour:
- All outputs are registered. Reset (rst_n=0 at a rising edge) forces:
  - state=IDLE, busy=0, done=0, diff=0, borrow_out=0;
  - bit counter, operand shift registers, partial-result register and internal borrow all 0.
- Reset mid-operation aborts the operation. No done pulse is issued for it, and the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 at edge E0 latches a, b and borrow_in into internal registers; counter=0; goes to SHIFT (busy=1 after E0). With start=0, stays in IDLE.
  - SHIFT: each edge processes the current LSBs a0, b0 and internal borrow br:
    - d = a0 ^ b0 ^ br;
    - br' = (~a0 & b0) | (~a0 & br) | (b0 & br);
    - a_sh and b_sh shift right by 1; d enters the partial result at its MSB; counter increments.
  - SHIFT exit: on the edge where counter == WIDTH-1 (edge E_WIDTH):
    - diff <= {d, partial[WIDTH-1:1]} and borrow_out <= br';
    - state goes to DONE; busy=0; done=1.
  - DONE: lasts exactly one cycle (done=1).
    - start=1 at the next edge: new operands are accepted exactly as from IDLE, giving back-to-back operation. done drops and busy rises.
    - start=0: goes to IDLE, done=0.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH edges after the accepting edge. Minimum issue interval is WIDTH+1 cycles.
- start while in SHIFT is ignored. No queuing, no error flag.
- Changes on a, b or borrow_in outside the accepting edge have no effect.
- diff and borrow_out hold their value until the next completion or reset. They are not disturbed while a new operation is shifting.
- Counter width is $clog2(WIDTH). The counter never wraps beyond WIDTH-1 within an operation.
- Arithmetic is unsigned and modulo 2^WIDTH. For two's-complement operands, borrow_out is the carry-not indicator, not signed overflow.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, borrow_in=0, start pulse at E0 -> busy high for 8 cycles; done 8 edges after E0; diff=0x1E, borrow_out=0.
2. a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Then a=0x00, b=0xFF, borrow_in=1 -> diff=0x00, borrow_out=1. Then a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0.
3. Mid-operation: start a=0x80, b=0x01. At the 3rd SHIFT cycle, assert start with a=0xFF, b=0xFF and also change the a/b ports -> second start ignored; result diff=0x7F, borrow_out=0.
4. Reset: start a=0x33, b=0x11. Drive rst_n=0 for one edge at the 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0x00, borrow_out=0; no done pulse for that operation. A subsequent start completes normally.
5. Back-to-back: hold start=1 in the DONE cycle with new operands a=0x02, b=0x03 -> first result held while the second operation runs. Second done exactly 9 cycles after the first; diff=0xFF, borrow_out=1.
6. Random: 1000 random {a, b, borrow_in} for WIDTH=8 and WIDTH=13, with random idle gaps -> each done matches the model {borrow_out, diff} = {a - b - borrow_in} in WIDTH+1 bits. Also checks that done is a 1-cycle pulse and busy never overlaps done.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives operands and start; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtract cell and a registered borrow are reused every cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q;

  logic d;
  logic br_n;
  logic last;
  logic accept;

  assign d      = a_q[0] ^ b_q[0] ^ br_q;
  assign br_n   = (~a_q[0] & b_q[0])
                | (~a_q[0] & br_q)
                | (b_q[0] & br_q);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = bus.start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // diff/borrow_out only move on the final bit, so they hold across a new run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      part_q <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      a_q    <= bus.a;
      b_q    <= bus.b;
      br_q   <= bus.borrow_in;
      part_q <= '0;
    end else if (state_q == SHIFT) begin
      cnt_q  <= cnt_q + 1'b1;
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= br_n;
      part_q <= {d, part_q[WIDTH-1:1]};
      if (last) begin
        diff_q <= {d, part_q[WIDTH-1:1]};
        bo_q   <= br_n;
      end
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8 and 13.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(13)) bus13 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic done8_prev = 1'b0;
  logic done13_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("overlap8", 32'(bus8.busy & bus8.done), 32'd0);
      chk("pulse8", 32'(bus8.done & done8_prev), 32'd0);
      chk("overlap13", 32'(bus13.busy & bus13.done), 32'd0);
      chk("pulse13", 32'(bus13.done & done13_prev), 32'd0);
    end
    done8_prev  = bus8.done;
    done13_prev = bus13.done;
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic bi);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.borrow_in = bi;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    bus8.borrow_in = 1'($urandom);
  endtask

  task automatic issue13(input logic [12:0] a, input logic [12:0] b,
                         input logic bi);
    bus13.start = 1'b1;
    bus13.a = a;
    bus13.b = b;
    bus13.borrow_in = bi;
    @(negedge clk);
    bus13.start = 1'b0;
    bus13.a = 13'($urandom);
    bus13.b = 13'($urandom);
    bus13.borrow_in = 1'($urandom);
  endtask

  task automatic wait8(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus8.done) chk("timeout8", 32'd0, 32'd1);
  endtask

  task automatic wait13(output int lat);
    lat = 1;
    while (!bus13.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus13.done) chk("timeout13", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [7:0]  ra, rb;
    logic [12:0] qa, qb;
    logic        rbi;
    logic [8:0]  e9;
    logic [13:0] e14;

    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.borrow_in = 1'b0;
    bus13.start = 1'b0;
    bus13.a = '0;
    bus13.b = '0;
    bus13.borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_diff", 32'(bus8.diff), 32'd0);
    chk("rst_bo", 32'(bus8.borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic
    issue8(8'h5A, 8'h3C, 1'b0);
    chk("t1_busy", 32'(bus8.busy), 32'd1);
    wait8(lat, bcnt);
    chk("t1_lat", 32'(lat), 32'd9);
    chk("t1_busycnt", 32'(bcnt), 32'd8);
    chk("t1_diff", 32'(bus8.diff), 32'h1E);
    chk("t1_bo", 32'(bus8.borrow_out), 32'd0);
    @(negedge clk);
    chk("t1_idle_done", 32'(bus8.done), 32'd0);
    chk("t1_hold", 32'(bus8.diff), 32'h1E);

    // 2: boundaries
    issue8(8'h00, 8'h01, 1'b0);
    wait8(lat, bcnt);
    chk("t2a", 32'({bus8.borrow_out, bus8.diff}), 32'h1FF);
    @(negedge clk);
    issue8(8'h00, 8'hFF, 1'b1);
    wait8(lat, bcnt);
    chk("t2b", 32'({bus8.borrow_out, bus8.diff}), 32'h100);
    @(negedge clk);
    issue8(8'h10, 8'h0F, 1'b1);
    wait8(lat, bcnt);
    chk("t2c", 32'({bus8.borrow_out, bus8.diff}), 32'h000);
    @(negedge clk);

    // 3: start during SHIFT is ignored
    issue8(8'h80, 8'h01, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(lat, bcnt);
    chk("t3_lat", 32'(lat), 32'd7);
    chk("t3", 32'({bus8.borrow_out, bus8.diff}), 32'h07F);
    @(negedge clk);
    chk("t3_idle", 32'(bus8.busy), 32'd0);

    // 4: reset mid-operation
    issue8(8'h33, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_busy", 32'(bus8.busy), 32'd0);
    chk("t4_done", 32'(bus8.done), 32'd0);
    chk("t4_diff", 32'(bus8.diff), 32'd0);
    chk("t4_bo", 32'(bus8.borrow_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_nodone", 32'(bus8.done), 32'd0);
    end
    issue8(8'h33, 8'h11, 1'b0);
    wait8(lat, bcnt);
    chk("t4_after", 32'({bus8.borrow_out, bus8.diff}), 32'h022);
    @(negedge clk);

    // 5: back-to-back
    issue8(8'h07, 8'h02, 1'b0);
    wait8(lat, bcnt);
    chk("t5_first", 32'({bus8.borrow_out, bus8.diff}), 32'h005);
    issue8(8'h02, 8'h03, 1'b0);
    chk("t5_busy", 32'(bus8.busy), 32'd1);
    chk("t5_held", 32'({bus8.borrow_out, bus8.diff}), 32'h005);
    wait8(lat, bcnt);
    chk("t5_lat", 32'(lat), 32'd9);
    chk("t5_second", 32'({bus8.borrow_out, bus8.diff}), 32'h1FF);

    // 6: random, WIDTH=8
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbi = 1'($urandom);
      e9 = {1'b0, ra} - {1'b0, rb} - 9'(rbi);
      issue8(ra, rb, rbi);
      wait8(lat, bcnt);
      chk("rnd8", 32'({bus8.borrow_out, bus8.diff}), 32'(e9));
    end
    @(negedge clk);

    // 6: random, WIDTH=13
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      qa = 13'($urandom);
      qb = 13'($urandom);
      rbi = 1'($urandom);
      e14 = {1'b0, qa} - {1'b0, qb} - 14'(rbi);
      issue13(qa, qb, rbi);
      wait13(lat);
      chk("rnd13_lat", 32'(lat), 32'd14);
      chk("rnd13", 32'({bus13.borrow_out, bus13.diff}), 32'(e14));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
